sentinel_seq_lock: RTL and testbench

Parametrised, clocked successor to the single-byte Sentinel gate. It accepts a multi-byte authorization key as a strobed byte stream and compares the whole sequence without early rejection. Failed attempts are counted, and the block enforces a timed lockout after MAX_FAILS consecutive failures. It sits between the DIP/key interface and the 7-segment/status outputs of the Citadel perimeter design.

---
 rtl/sentinel_seq_lock_if.sv | 29 ++
 rtl/sentinel_seq_lock.sv | 134 +++++++++++++
 tb/tb_sentinel_seq_lock.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sentinel_seq_lock_if.sv
// Byte-stream key entry and status bundle for sentinel_seq_lock.
// The master side drives the key stream, the slave side reports lock status.
interface sentinel_seq_lock_if #(
    parameter int unsigned KEY_BYTES = 4,
    parameter int unsigned MAX_FAILS = 3
);
    localparam int unsigned FW = $clog2(MAX_FAILS + 1);
    localparam int unsigned PW = $clog2(KEY_BYTES + 1);

    logic          ena;
    logic [7:0]    key_byte;
    logic          key_valid;
    logic          relock;
    logic [7:0]    seg;
    logic          unlocked;
    logic          locked_out;
    logic [FW-1:0] fail_count;
    logic [PW-1:0] progress;

    modport master (
        output ena, key_byte, key_valid, relock,
        input  seg, unlocked, locked_out, fail_count, progress
    );

    modport slave (
        input  ena, key_byte, key_valid, relock,
        output seg, unlocked, locked_out, fail_count, progress
    );
endinterface

// File: rtl/sentinel_seq_lock.sv
// Multi-byte sequence lock: whole-key comparison, consecutive-failure counting
// and a timed lockout, all frozen while ena is low.
module sentinel_seq_lock #(
    parameter int unsigned              KEY_BYTES      = 4,
    parameter logic [KEY_BYTES*8-1:0]   KEY            = 32'hB65AC31E,
    parameter int unsigned              MAX_FAILS      = 3,
    parameter int unsigned              LOCKOUT_CYCLES = 1024,
    parameter int unsigned              TIMEOUT_CYCLES = 256
) (
    input logic                clk,
    input logic                rst,
    sentinel_seq_lock_if.slave bus
);
    localparam int unsigned FW = $clog2(MAX_FAILS + 1);
    localparam int unsigned PW = $clog2(KEY_BYTES + 1);
    localparam int unsigned LW = $clog2(LOCKOUT_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [PW-1:0] LAST_IDX  = PW'(KEY_BYTES - 1);
    localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAILS);
    localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAILS - 1);
    localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES - 1);
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StLocked, StCollect, StUnlocked, StLockout} state_e;

    state_e        state_q, state_d;
    logic [FW-1:0] fail_q, fail_d;
    logic [PW-1:0] prog_q, prog_d;
    logic          mismatch_q, mismatch_d;
    logic [LW-1:0] timer_q, timer_d;
    logic [TW-1:0] idle_q, idle_d;

    logic [7:0]    exp_byte;
    logic          attempt_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StLocked;
            fail_q     <= '0;
            prog_q     <= '0;
            mismatch_q <= 1'b0;
            timer_q    <= '0;
            idle_q     <= '0;
        end else begin
            state_q    <= state_d;
            fail_q     <= fail_d;
            prog_q     <= prog_d;
            mismatch_q <= mismatch_d;
            timer_q    <= timer_d;
            idle_q     <= idle_d;
        end
    end

    // Key bytes are consumed MSB-first; progress is the index of the next byte.
    always_comb begin
        exp_byte    = 8'(KEY >> (8 * (KEY_BYTES - 1 - 32'(prog_q))));
        // The sticky flag only carries over within an attempt already in progress.
        attempt_bad = (bus.key_byte != exp_byte) || ((state_q == StCollect) && mismatch_q);
    end

    always_comb begin
        state_d    = state_q;
        fail_d     = fail_q;
        prog_d     = prog_q;
        mismatch_d = mismatch_q;
        timer_d    = timer_q;
        idle_d     = idle_q;

        if (bus.ena) begin
            unique case (state_q)
                StLocked, StCollect: begin
                    if (bus.key_valid) begin
                        idle_d = '0;
                        if (prog_q == LAST_IDX) begin
                            prog_d = '0;
                            if (!attempt_bad) begin
                                state_d = StUnlocked;
                                fail_d  = '0;
                            end else if (fail_q == FAIL_LAST) begin
                                state_d = StLockout;
                                fail_d  = FAIL_MAX;
                                timer_d = LOCK_LOAD;
                            end else begin
                                state_d = StLocked;
                                fail_d  = fail_q + FW'(1);
                            end
                        end else begin
                            state_d    = StCollect;
                            prog_d     = prog_q + PW'(1);
                            mismatch_d = attempt_bad;
                        end
                    end else if (state_q == StCollect) begin
                        // Abandoned attempts drop back without counting as failures.
                        if (idle_q == IDLE_LAST) begin
                            state_d = StLocked;
                            prog_d  = '0;
                            idle_d  = '0;
                        end else begin
                            idle_d = idle_q + TW'(1);
                        end
                    end
                end
                StUnlocked: begin
                    if (bus.relock) state_d = StLocked;
                end
                StLockout: begin
                    if (timer_q == '0) begin
                        state_d = StLocked;
                        fail_d  = '0;
                    end else begin
                        timer_d = timer_q - LW'(1);
                    end
                end
                default: state_d = StLocked;
            endcase
        end
    end

    always_comb begin
        bus.seg = 8'hFF;
        if (bus.ena) begin
            unique case (state_q)
                StUnlocked: bus.seg = 8'hC1;
                StLockout:  bus.seg = 8'hBF;
                default:    bus.seg = 8'hC7;
            endcase
        end
        bus.unlocked   = bus.ena && (state_q == StUnlocked);
        bus.locked_out = (state_q == StLockout);
        bus.fail_count = fail_q;
        bus.progress   = prog_q;
    end
endmodule

// File: tb/tb_sentinel_seq_lock.sv
// Directed bench for sentinel_seq_lock: unlock, failures, lockout, timeout,
// enable freeze and reset, each scenario checking its own hand-computed values.
module tb_sentinel_seq_lock;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sentinel_seq_lock_if #(.KEY_BYTES(4), .MAX_FAILS(3)) bus ();

    sentinel_seq_lock #(
        .KEY_BYTES(4), .KEY(32'hB65AC31E), .MAX_FAILS(3),
        .LOCKOUT_CYCLES(1024), .TIMEOUT_CYCLES(256)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.key_byte  = b;
        bus.key_valid = 1'b1;
        step();
        bus.key_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send(w[31-8*i -: 8]);
    endtask

    task automatic pulse_relock();
        bus.relock = 1'b1;
        step();
        bus.relock = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.ena = 1'b0;
        step();
        step();
        checks++;
        if (bus.seg !== 8'hFF) begin
            errors++;
            $display("FAIL reset_seg_ena0 got %h want ff", bus.seg);
        end
        checks++;
        if ({bus.unlocked, bus.locked_out, bus.fail_count, bus.progress} !== 7'b0) begin
            errors++;
            $display("FAIL reset_state got u=%b lo=%b f=%0d p=%0d want all 0",
                     bus.unlocked, bus.locked_out, bus.fail_count, bus.progress);
        end
        bus.ena = 1'b1;
        #1;
        checks++;
        if (bus.seg !== 8'hC7) begin
            errors++;
            $display("FAIL reset_seg_ena1 got %h want c7", bus.seg);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_unlock();
        send(8'hB6);
        send(8'h5A);
        send(8'hC3);
        checks++;
        if (bus.progress !== 3'd3 || bus.unlocked !== 1'b0) begin
            errors++;
            $display("FAIL unlock_partial got p=%0d u=%b want p=3 u=0", bus.progress, bus.unlocked);
        end
        send(8'h1E);
        checks++;
        if (bus.unlocked !== 1'b1 || bus.seg !== 8'hC1 || bus.fail_count !== 2'd0
            || bus.progress !== 3'd0) begin
            errors++;
            $display("FAIL unlock_done got u=%b seg=%h f=%0d p=%0d want u=1 seg=c1 f=0 p=0",
                     bus.unlocked, bus.seg, bus.fail_count, bus.progress);
        end
        bus.ena = 1'b0;
        #1;
        checks++;
        if (bus.unlocked !== 1'b0 || bus.seg !== 8'hFF) begin
            errors++;
            $display("FAIL unlock_ena0 got u=%b seg=%h want u=0 seg=ff", bus.unlocked, bus.seg);
        end
        bus.ena = 1'b1;
        send(8'hB6);
        checks++;
        if (bus.unlocked !== 1'b1 || bus.progress !== 3'd0) begin
            errors++;
            $display("FAIL unlock_ignores_key got u=%b p=%0d want u=1 p=0",
                     bus.unlocked, bus.progress);
        end
        pulse_relock();
        checks++;
        if (bus.unlocked !== 1'b0 || bus.seg !== 8'hC7) begin
            errors++;
            $display("FAIL relock got u=%b seg=%h want u=0 seg=c7", bus.unlocked, bus.seg);
        end
    endtask

    task automatic test_bad_attempt();
        logic [31:0] w = 32'hB65AC31F;
        int          bad = 0;
        for (int i = 0; i < 3; i++) begin
            send(w[31-8*i -: 8]);
            if (bus.progress !== 3'(i + 1)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bad_progress got %0d wrong steps want 0", bad);
        end
        send(w[7:0]);
        checks++;
        if (bus.unlocked !== 1'b0 || bus.fail_count !== 2'd1 || bus.progress !== 3'd0) begin
            errors++;
            $display("FAIL bad_eval got u=%b f=%0d p=%0d want u=0 f=1 p=0",
                     bus.unlocked, bus.fail_count, bus.progress);
        end
        pulse_relock();
        checks++;
        if (bus.fail_count !== 2'd1 || bus.seg !== 8'hC7) begin
            errors++;
            $display("FAIL relock_in_locked got f=%0d seg=%h want f=1 seg=c7",
                     bus.fail_count, bus.seg);
        end
    endtask

    task automatic test_lockout();
        int bad = 0;
        int n   = 0;
        logic [31:0] good = 32'hB65AC31E;
        // Wrong first byte still walks through all four bytes.
        send(8'h00);
        if (bus.progress !== 3'd1) bad++;
        send(8'h5A);
        if (bus.progress !== 3'd2) bad++;
        send(8'hC3);
        if (bus.progress !== 3'd3) bad++;
        send(8'h1E);
        checks++;
        if (bad != 0 || bus.fail_count !== 2'd2 || bus.locked_out !== 1'b0) begin
            errors++;
            $display("FAIL second_fail got badsteps=%0d f=%0d lo=%b want 0 f=2 lo=0",
                     bad, bus.fail_count, bus.locked_out);
        end
        send_word(32'hB65AC300);
        checks++;
        if (bus.locked_out !== 1'b1 || bus.fail_count !== 2'd3 || bus.seg !== 8'hBF) begin
            errors++;
            $display("FAIL lockout_entry got lo=%b f=%0d seg=%h want lo=1 f=3 seg=bf",
                     bus.locked_out, bus.fail_count, bus.seg);
        end
        bad = 0;
        while (bus.locked_out === 1'b1 && n < 2000) begin
            if (bus.seg !== 8'hBF || bus.unlocked !== 1'b0 || bus.progress !== 3'd0) bad++;
            if (n < 4) begin
                bus.key_byte  = good[31-8*n -: 8];
                bus.key_valid = 1'b1;
            end
            step();
            bus.key_valid = 1'b0;
            n++;
        end
        checks++;
        if (n != 1024) begin
            errors++;
            $display("FAIL lockout_len got %0d cycles want 1024", n);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL lockout_hold got %0d bad cycles want 0", bad);
        end
        checks++;
        if (bus.seg !== 8'hC7 || bus.fail_count !== 2'd0 || bus.progress !== 3'd0
            || bus.unlocked !== 1'b0) begin
            errors++;
            $display("FAIL lockout_exit got seg=%h f=%0d p=%0d u=%b want c7 0 0 0",
                     bus.seg, bus.fail_count, bus.progress, bus.unlocked);
        end
        send_word(good);
        checks++;
        if (bus.unlocked !== 1'b1) begin
            errors++;
            $display("FAIL unlock_after_lockout got u=%b want 1", bus.unlocked);
        end
        pulse_relock();
    endtask

    task automatic test_timeout();
        send(8'hB6);
        send(8'h5A);
        repeat (255) step();
        checks++;
        if (bus.progress !== 3'd2) begin
            errors++;
            $display("FAIL timeout_early got p=%0d want 2", bus.progress);
        end
        step();
        checks++;
        if (bus.progress !== 3'd0 || bus.fail_count !== 2'd0) begin
            errors++;
            $display("FAIL timeout_fire got p=%0d f=%0d want p=0 f=0",
                     bus.progress, bus.fail_count);
        end
        // A strobe on the expiring cycle is accepted instead.
        send(8'hB6);
        repeat (255) step();
        send(8'h5A);
        checks++;
        if (bus.progress !== 3'd2) begin
            errors++;
            $display("FAIL timeout_race got p=%0d want 2", bus.progress);
        end
        send(8'hC3);
        send(8'h1E);
        checks++;
        if (bus.unlocked !== 1'b1) begin
            errors++;
            $display("FAIL timeout_then_unlock got u=%b want 1", bus.unlocked);
        end
        pulse_relock();
    endtask

    task automatic test_ena_freeze();
        int bad = 0;
        int n   = 0;
        repeat (3) send_word(32'h00000000);
        checks++;
        if (bus.locked_out !== 1'b1) begin
            errors++;
            $display("FAIL freeze_entry got lo=%b want 1", bus.locked_out);
        end
        repeat (10) step();
        bus.ena = 1'b0;
        bus.key_byte = 8'hB6;
        bus.key_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (bus.seg !== 8'hFF || bus.locked_out !== 1'b1 || bus.progress !== 3'd0
                || bus.fail_count !== 2'd3) bad++;
        end
        bus.key_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL freeze_hold got %0d bad cycles want 0", bad);
        end
        bus.ena = 1'b1;
        #1;
        while (bus.locked_out === 1'b1 && n < 2000) begin
            step();
            n++;
        end
        checks++;
        if (n != 1014) begin
            errors++;
            $display("FAIL freeze_remaining got %0d cycles want 1014", n);
        end
        send(8'hB6);
        bus.ena = 1'b0;
        send(8'h5A);
        send(8'hC3);
        checks++;
        if (bus.progress !== 3'd1) begin
            errors++;
            $display("FAIL freeze_collect got p=%0d want 1", bus.progress);
        end
        bus.ena = 1'b1;
        send(8'h5A);
        send(8'hC3);
        send(8'h1E);
        checks++;
        if (bus.unlocked !== 1'b1) begin
            errors++;
            $display("FAIL freeze_unlock got u=%b want 1", bus.unlocked);
        end
        pulse_relock();
    endtask

    task automatic test_reset_mid();
        send_word(32'h11111111);
        send_word(32'h22222222);
        send(8'hB6);
        send(8'h5A);
        checks++;
        if (bus.fail_count !== 2'd2 || bus.progress !== 3'd2) begin
            errors++;
            $display("FAIL pre_reset got f=%0d p=%0d want f=2 p=2", bus.fail_count, bus.progress);
        end
        rst = 1'b1;
        bus.key_byte = 8'hC3;
        bus.key_valid = 1'b1;
        step();
        rst = 1'b0;
        bus.key_valid = 1'b0;
        checks++;
        if (bus.fail_count !== 2'd0 || bus.progress !== 3'd0 || bus.locked_out !== 1'b0
            || bus.unlocked !== 1'b0 || bus.seg !== 8'hC7) begin
            errors++;
            $display("FAIL mid_reset got f=%0d p=%0d lo=%b u=%b seg=%h want 0 0 0 0 c7",
                     bus.fail_count, bus.progress, bus.locked_out, bus.unlocked, bus.seg);
        end
        send_word(32'hB65AC31F);
        checks++;
        if (bus.fail_count !== 2'd1 || bus.locked_out !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_fail got f=%0d lo=%b want f=1 lo=0",
                     bus.fail_count, bus.locked_out);
        end
    endtask

    initial begin
        bus.ena       = 1'b0;
        bus.key_byte  = 8'h00;
        bus.key_valid = 1'b0;
        bus.relock    = 1'b0;
        rst           = 1'b1;
        test_reset();
        test_unlock();
        test_bad_attempt();
        test_lockout();
        test_timeout();
        test_ena_freeze();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
